// File: rtl/sys_bridge_timer_pkg.sv
// Shared definitions for the CPU data-bus responder: address map, timer
// register offsets, CTRL bit positions, mode encodings, timer FSM states and
// the timer-window hit test.
package sys_bridge_timer_pkg;

  localparam int          MAP_DM_WORDS = 3072;
  localparam logic [31:0] MAP_T0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] MAP_T1_BASE  = 32'h0000_7F10;

  // Each timer owns a 16-byte window; only the first three words hold registers.
  localparam logic [31:0] TMR_SPAN = 32'd16;

  localparam logic [1:0] IDX_CTRL   = 2'd0;  // +0
  localparam logic [1:0] IDX_PRESET = 2'd1;  // +4
  localparam logic [1:0] IDX_COUNT  = 2'd2;  // +8

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

  function automatic logic tmr_hit(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base) && ((addr - base) < TMR_SPAN);
  endfunction

endpackage

// File: rtl/sys_bridge_timer_bus_timer.sv
// One interval timer: CTRL/PRESET/COUNT registers, the IDLE/LOAD/CNT/INT
// state machine and the masked interrupt output.
//  clk, reset : clock, asynchronous active-high reset
//  wr_en      : accepted full-word write to this timer
//  idx        : register word index within the timer window
//  wdata      : write data
//  rdata      : register read data for idx (0 for the reserved word)
//  irq        : flag & IM
module bus_timer
  import sys_bridge_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  idx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tmr_state_e  state;
  tmr_state_e  state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        flag;
  logic        en;
  logic        auto_rld;
  logic        wr_ctrl;
  logic        wr_preset;

  // COUNT stops at zero; it never wraps.
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v > 32'd1) ? v - 32'd1 : 32'd0;
  endfunction

  assign en        = ctrl[CTRL_EN];
  assign auto_rld  = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);
  assign wr_ctrl   = wr_en && (idx == IDX_CTRL);
  assign wr_preset = wr_en && (idx == IDX_PRESET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_CNT;
      ST_CNT: begin
        if (!en)                  state_nxt = ST_IDLE;
        else if (count <= 32'd1)  state_nxt = ST_INT;
      end
      ST_INT:  state_nxt = auto_rld ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // CPU register writes are placed after the FSM actions so a CTRL write on
  // the same edge as the one-shot En clear takes precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: count <= preset;
        ST_CNT: begin
          if (en) begin
            count <= sat_dec(count);
            if (count <= 32'd1) flag <= 1'b1;
          end
        end
        ST_INT: begin
          if (auto_rld) flag <= 1'b0;
          else          ctrl[CTRL_EN] <= 1'b0;
        end
        default: ;
      endcase
      if (wr_ctrl)   ctrl   <= wdata[3:0];
      if (wr_preset) preset <= wdata;
      if ((wr_ctrl || wr_preset) && !auto_rld) flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_CTRL:   rdata = {28'b0, ctrl};
      IDX_PRESET: rdata = preset;
      IDX_COUNT:  rdata = count;
      default:    rdata = '0;
    endcase
    irq = flag & ctrl[CTRL_IM];
  end

endmodule

// File: rtl/sys_bridge_timer.sv
// Responder for the CPU data bus: decodes data memory and two interval
// timers, returns read data combinationally, applies byte-enabled writes on
// the clock edge and packs the CPU interrupt vector.
//  clk, reset     : clock, asynchronous active-high reset
//  m_data_addr    : byte address (word access)
//  m_data_wdata   : write data
//  m_data_byteen  : per-lane write enable
//  m_data_re      : read request
//  ext_int        : external interrupt, forwarded to HWInt[2]
//  m_data_rdata   : read data
//  bus_err        : access to an unmapped address
//  HWInt          : {3'b0, ext_int, t1_irq, t0_irq}
module sys_bridge_timer
  import sys_bridge_timer_pkg::*;
#(
  parameter int          DM_WORDS = MAP_DM_WORDS,
  parameter logic [31:0] T0_BASE  = MAP_T0_BASE,
  parameter logic [31:0] T1_BASE  = MAP_T1_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic        m_data_re,
  input  logic        ext_int,
  output logic [31:0] m_data_rdata,
  output logic        bus_err,
  output logic [5:0]  HWInt
);

  localparam int          DM_IDX_W = $clog2(DM_WORDS);
  localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS * 4);

  logic [31:0]         dm [DM_WORDS];
  logic [DM_IDX_W-1:0] dm_idx;
  logic                dm_sel;
  logic                t0_sel;
  logic                t1_sel;
  logic [31:0]         t0_off;
  logic [31:0]         t1_off;
  logic                wr_full;
  logic [31:0]         t0_rdata;
  logic [31:0]         t1_rdata;
  logic                t0_irq;
  logic                t1_irq;

  assign dm_sel  = (m_data_addr < DM_LIMIT);
  assign dm_idx  = m_data_addr[DM_IDX_W+1:2];
  // The word at +12 is a reserved hole inside the timer window: it reads 0
  // and ignores writes but does not raise bus_err.
  assign t0_sel  = tmr_hit(m_data_addr, T0_BASE);
  assign t1_sel  = tmr_hit(m_data_addr, T1_BASE);
  assign t0_off  = m_data_addr - T0_BASE;
  assign t1_off  = m_data_addr - T1_BASE;
  assign wr_full = (m_data_byteen == 4'hF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm[i] <= '0;
    end else if (dm_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (m_data_byteen[b]) dm[dm_idx][8*b +: 8] <= m_data_wdata[8*b +: 8];
      end
    end
  end

  bus_timer u_t0 (
    .clk   (clk),
    .reset (reset),
    .wr_en (t0_sel && wr_full),
    .idx   (t0_off[3:2]),
    .wdata (m_data_wdata),
    .rdata (t0_rdata),
    .irq   (t0_irq)
  );

  bus_timer u_t1 (
    .clk   (clk),
    .reset (reset),
    .wr_en (t1_sel && wr_full),
    .idx   (t1_off[3:2]),
    .wdata (m_data_wdata),
    .rdata (t1_rdata),
    .irq   (t1_irq)
  );

  always_comb begin
    m_data_rdata = '0;
    if (dm_sel)      m_data_rdata = dm[dm_idx];
    else if (t0_sel) m_data_rdata = t0_rdata;
    else if (t1_sel) m_data_rdata = t1_rdata;
  end

  assign bus_err = !(dm_sel || t0_sel || t1_sel) && (m_data_re || (m_data_byteen != 4'h0));
  assign HWInt   = {3'b0, ext_int, t1_irq, t0_irq};

endmodule

// File: tb/tb_sys_bridge_timer.sv
module tb_sys_bridge_timer;

  localparam logic [31:0] T0 = 32'h7F00;
  localparam logic [31:0] T1 = 32'h7F10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m_data_addr = '0;
  logic [31:0] m_data_wdata = '0;
  logic [3:0]  m_data_byteen = '0;
  logic        m_data_re = 1'b0;
  logic        ext_int = 1'b0;
  logic [31:0] m_data_rdata;
  logic        bus_err;
  logic [5:0]  HWInt;

  int n_cmp = 0;
  int n_err = 0;

  sys_bridge_timer dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_re     (m_data_re),
    .ext_int       (ext_int),
    .m_data_rdata  (m_data_rdata),
    .bus_err       (bus_err),
    .HWInt         (HWInt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_data_re     = 1'b0;
    @(posedge clk);
    #1;
    m_data_byteen = 4'h0;
  endtask

  task automatic setrd(input logic [31:0] a);
    m_data_addr   = a;
    m_data_re     = 1'b1;
    m_data_byteen = 4'h0;
    #1;
  endtask

  initial begin
    // reset state
    ext_int = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_hwint", 32'(HWInt), 32'h04);
    setrd(T0 + 8);
    chk("rst_t0_count", m_data_rdata, 32'h0);
    setrd(32'h10);
    chk("rst_dm", m_data_rdata, 32'h0);
    ext_int = 1'b0;
    step();
    step();
    reset = 1'b0;

    // 1: DM byte lanes
    wr(32'h10, 32'h1122_3344, 4'hF);
    wr(32'h10, 32'hAABB_CCDD, 4'b0101);
    setrd(32'h10);
    chk("dm_lanes", m_data_rdata, 32'h11BB_33DD);
    chk("dm_bus_err", 32'(bus_err), 32'h0);

    // 2: one-shot, PRESET=3
    wr(T0 + 4, 32'd3, 4'hF);
    wr(T0 + 0, 32'h9, 4'hF);
    setrd(T0 + 8);
    step();
    chk("os_count_e1", m_data_rdata, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("os_count", m_data_rdata, 32'(5 - k));
      chk("os_hwint", 32'(HWInt), (k == 5) ? 32'h01 : 32'h00);
    end
    step();
    chk("os_hwint_e6", 32'(HWInt), 32'h01);
    setrd(T0 + 0);
    chk("os_ctrl_en_clr", m_data_rdata, 32'h8);
    wr(T0 + 4, 32'd3, 4'hF);
    chk("os_flag_clr", 32'(HWInt), 32'h00);

    // 3: auto-reload on T1, PRESET=2 -> pulse every 4 cycles
    wr(T1 + 4, 32'd2, 4'hF);
    wr(T1 + 0, 32'hB, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("ar_pulse", 32'(HWInt), (k % 4 == 0) ? 32'h02 : 32'h00);
    end
    wr(T1 + 0, 32'h0, 4'hF);

    // 4a: IM=0 -> count expires, no interrupt
    wr(T0 + 0, 32'h1, 4'hF);
    setrd(T0 + 8);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("mask_hwint", 32'(HWInt), 32'h00);
      if (k == 5) chk("mask_count0", m_data_rdata, 32'd0);
    end

    // 4b: stop mid-count, COUNT freezes
    wr(T0 + 4, 32'd10, 4'hF);
    wr(T0 + 0, 32'h1, 4'hF);
    setrd(T0 + 8);
    step();
    step();
    step();
    step();
    chk("stop_pre", m_data_rdata, 32'd8);
    wr(T0 + 0, 32'h0, 4'hF);
    setrd(T0 + 8);
    chk("stop_edge", m_data_rdata, 32'd7);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stop_frozen", m_data_rdata, 32'd7);
    end
    setrd(T0 + 0);
    chk("stop_ctrl", m_data_rdata, 32'h0);

    // 5: error and ignored accesses
    setrd(T0 + 12);
    chk("rsv_rdata", m_data_rdata, 32'h0);
    chk("rsv_bus_err", 32'(bus_err), 32'h0);
    setrd(32'h4000);
    chk("unm_rdata", m_data_rdata, 32'h0);
    chk("unm_bus_err_rd", 32'(bus_err), 32'h1);
    m_data_re = 1'b0;
    #1;
    chk("unm_idle_no_err", 32'(bus_err), 32'h0);
    m_data_byteen = 4'h2;
    #1;
    chk("unm_bus_err_wr", 32'(bus_err), 32'h1);
    m_data_byteen = 4'h0;
    m_data_addr   = T0 + 4;
    m_data_wdata  = 32'h55;
    m_data_byteen = 4'b0011;
    #1;
    chk("part_bus_err", 32'(bus_err), 32'h0);
    step();
    m_data_byteen = 4'h0;
    setrd(T0 + 4);
    chk("part_ignored", m_data_rdata, 32'd10);

    // 6: T1 one-shot leaves irq high, then reset in the middle of a T0 count
    wr(T1 + 4, 32'd1, 4'hF);
    wr(T1 + 0, 32'h9, 4'hF);
    step();
    step();
    step();
    chk("t1_irq_set", 32'(HWInt), 32'h02);
    wr(T0 + 4, 32'd100, 4'hF);
    wr(T0 + 0, 32'h9, 4'hF);
    setrd(T0 + 8);
    for (int k = 0; k < 52; k++) step();
    chk("mid_count", m_data_rdata, 32'd50);
    chk("mid_hwint", 32'(HWInt), 32'h02);
    #2 reset = 1'b1;
    #1;
    chk("arst_hwint", 32'(HWInt), 32'h00);
    chk("arst_count", m_data_rdata, 32'h0);
    setrd(T0 + 0);
    chk("arst_ctrl", m_data_rdata, 32'h0);
    setrd(32'h10);
    chk("arst_dm", m_data_rdata, 32'h0);
    step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
